// File: rtl/if_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_fetch_stage
//
// Instruction-fetch stage. Owns the program counter, presents it directly to
// a 64-word instruction memory, and captures the word the memory returns in
// the same cycle into the IF/ID pipeline register.
//
// Pipeline control (all sampled on the rising edge, highest priority first):
//   rst            - return to the reset state
//   redirect_valid - taken branch/jump: load redirect_pc (word aligned), flush
//                    IF/ID to a bubble, resume fetching. Overrides stall.
//   stall          - freeze PC, IF/ID, FSM state and fetch counter
//   (none)         - RUN: advance; HALT: feed bubbles into IF/ID
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   stall               hold request from the hazard unit
//   redirect_valid/_pc  branch/jump redirect from execute
//   imem_instruction    word at imem_pc, combinational from IMEM
//   imem_pc             byte address to IMEM (the PC register itself)
//   if_id_pc/_instruction/_valid   IF/ID pipeline register
//   halted              fetch is stopped (FSM in HALT)
//   fetch_count         valid instructions delivered, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module if_fetch_stage #(
    parameter logic [7:0]  RESET_PC  = 8'h00,
    parameter logic [31:0] HALT_WORD = 32'h0000_0073,
    parameter logic [31:0] NOP_WORD  = 32'h0000_0013,
    parameter logic [7:0]  LAST_PC   = 8'hFC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [7:0]  redirect_pc,
    input  logic [31:0] imem_instruction,
    output logic [7:0]  imem_pc,
    output logic [7:0]  if_id_pc,
    output logic [31:0] if_id_instruction,
    output logic        if_id_valid,
    output logic        halted,
    output logic [15:0] fetch_count
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

    fetch_state_e state_q;
    fetch_state_e state_d;

    logic [7:0] pc_q;

    // Fetch stops after delivering either a halt encoding or the last word.
    logic stop_fetch;
    assign stop_fetch = (imem_instruction == HALT_WORD) || (pc_q == LAST_PC);

    // IMEM sees the PC register directly; no extra registered stage.
    assign imem_pc = pc_q;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = ST_RUN;
        end else if (!stall) begin
            case (state_q)
                ST_RUN:  state_d = stop_fetch ? ST_HALT : ST_RUN;
                ST_HALT: state_d = ST_HALT;
                default: state_d = ST_RUN;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        halted = (state_q == ST_HALT);
    end

    // -------------------------------------------------------------------------
    // PC, IF/ID register and fetch counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q              <= RESET_PC;
            if_id_pc          <= 8'h00;
            if_id_instruction <= NOP_WORD;
            if_id_valid       <= 1'b0;
            fetch_count       <= 16'h0000;
        end else if (redirect_valid) begin
            // Misaligned low address bits are dropped. The word fetched this
            // cycle (even a halt encoding) is discarded; if_id_pc is left as is.
            pc_q              <= redirect_pc & ~8'h03;
            if_id_instruction <= NOP_WORD;
            if_id_valid       <= 1'b0;
        end else if (stall) begin
            pc_q              <= pc_q;
        end else if (state_q == ST_RUN) begin
            if_id_instruction <= imem_instruction;
            if_id_pc          <= pc_q;
            if_id_valid       <= 1'b1;
            if (fetch_count != 16'hFFFF) begin
                fetch_count <= fetch_count + 16'd1;
            end
            // No wrap past the last word: stop_fetch covers LAST_PC.
            if (!stop_fetch) begin
                pc_q <= pc_q + 8'd4;
            end
        end else begin
            // Halted: PC parked, bubbles flow into IF/ID.
            if_id_instruction <= NOP_WORD;
            if_id_valid       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_stage
//
// Directed vector table for the documented scenarios, followed by randomized
// stimulus compared against a transaction-level model of the fetch stage.
// -----------------------------------------------------------------------------
module tb_if_fetch_stage;

    localparam logic [31:0] HALT_WORD = 32'h0000_0073;
    localparam logic [31:0] NOP_WORD  = 32'h0000_0013;
    localparam logic [7:0]  LAST_PC   = 8'hFC;

    // ---------------------------------------------------------------- clock
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- DUT
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic [31:0] imem_instruction;
    logic [7:0]  imem_pc;
    logic [7:0]  if_id_pc;
    logic [31:0] if_id_instruction;
    logic        if_id_valid;
    logic        halted;
    logic [15:0] fetch_count;

    logic [31:0] imem [64];
    assign imem_instruction = imem[imem_pc[7:2]];

    if_fetch_stage dut (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .imem_instruction  (imem_instruction),
        .imem_pc           (imem_pc),
        .if_id_pc          (if_id_pc),
        .if_id_instruction (if_id_instruction),
        .if_id_valid       (if_id_valid),
        .halted            (halted),
        .fetch_count       (fetch_count)
    );

    // ---------------------------------------------------------------- checks
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] e_pc, input logic [7:0] e_ifpc,
                             input logic [31:0] e_instr, input logic e_valid,
                             input logic e_halt, input logic [15:0] e_cnt);
        check({tag, ".imem_pc"},     {24'h0, imem_pc},      {24'h0, e_pc});
        check({tag, ".if_id_pc"},    {24'h0, if_id_pc},     {24'h0, e_ifpc});
        check({tag, ".if_id_instr"}, if_id_instruction,     e_instr);
        check({tag, ".if_id_valid"}, {31'h0, if_id_valid},  {31'h0, e_valid});
        check({tag, ".halted"},      {31'h0, halted},       {31'h0, e_halt});
        check({tag, ".fetch_count"}, {16'h0, fetch_count},  {16'h0, e_cnt});
    endtask

    // Apply inputs, take one rising edge, settle, leave outputs ready to sample.
    task automatic drive_cycle(input logic r, input logic s, input logic rv, input logic [7:0] rp);
        rst = r; stall = s; redirect_valid = rv; redirect_pc = rp;
        @(posedge clk);
        #1;
    endtask

    // ---------------------------------------------------------------- directed table
    typedef struct {
        logic        rst;
        logic        stall;
        logic        rv;
        logic [7:0]  rpc;
        logic [7:0]  e_pc;
        logic [7:0]  e_ifpc;
        logic [31:0] e_instr;
        logic        e_valid;
        logic        e_halt;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mk(input logic r, input logic s, input logic rv, input logic [7:0] rp,
                                input logic [7:0] pc, input logic [7:0] ifpc, input logic [31:0] ins,
                                input logic v, input logic h, input logic [15:0] c);
        vec_t t;
        t.rst = r; t.stall = s; t.rv = rv; t.rpc = rp;
        t.e_pc = pc; t.e_ifpc = ifpc; t.e_instr = ins; t.e_valid = v; t.e_halt = h; t.e_cnt = c;
        return t;
    endfunction

    // ---------------------------------------------------------------- reference model
    // Abstract view: a fetch pointer that is either running or parked, plus the
    // last delivered {pc, word, valid} slot and a saturating delivery count.
    logic [7:0]  m_pc;
    logic        m_running;
    logic [7:0]  m_ifpc;
    logic [31:0] m_instr;
    logic        m_valid;
    int          m_cnt;

    task automatic model_step(input logic r, input logic s, input logic rv, input logic [7:0] rp);
        logic [31:0] w;
        w = imem[int'(m_pc) / 4];
        if (r) begin
            m_pc = 8'h00; m_running = 1'b1; m_ifpc = 8'h00;
            m_instr = NOP_WORD; m_valid = 1'b0; m_cnt = 0;
        end else if (rv) begin
            m_pc = 8'((int'(rp) / 4) * 4);
            m_running = 1'b1; m_instr = NOP_WORD; m_valid = 1'b0;
        end else if (!s) begin
            if (m_running) begin
                m_ifpc = m_pc; m_instr = w; m_valid = 1'b1;
                if (m_cnt < 65535) m_cnt = m_cnt + 1;
                if (w == HALT_WORD || m_pc == LAST_PC) m_running = 1'b0;
                else m_pc = m_pc + 8'd4;
            end else begin
                m_instr = NOP_WORD; m_valid = 1'b0;
            end
        end
    endtask

    // ---------------------------------------------------------------- test
    initial begin
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h00;

        for (int i = 0; i < 64; i++) imem[i] = 32'h1000_0000 | i;
        imem[0] = 32'h0050_0093;
        imem[1] = 32'h0030_8113;
        imem[4] = HALT_WORD;

        //             rst s  rv rpc      pc     ifpc   instr          v  h  cnt
        vecs.push_back(mk(1, 0, 0, 8'h00, 8'h00, 8'h00, NOP_WORD,      0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 8'h04, 8'h00, 32'h0050_0093, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 8'h00, 8'h08, 8'h04, 32'h0030_8113, 1, 0, 2));
        vecs.push_back(mk(0, 1, 0, 8'h00, 8'h08, 8'h04, 32'h0030_8113, 1, 0, 2));
        vecs.push_back(mk(0, 1, 0, 8'h00, 8'h08, 8'h04, 32'h0030_8113, 1, 0, 2));
        vecs.push_back(mk(0, 1, 0, 8'h00, 8'h08, 8'h04, 32'h0030_8113, 1, 0, 2));
        vecs.push_back(mk(0, 0, 0, 8'h00, 8'h0C, 8'h08, 32'h1000_0002, 1, 0, 3));
        vecs.push_back(mk(0, 0, 0, 8'h00, 8'h10, 8'h0C, 32'h1000_0003, 1, 0, 4));
        vecs.push_back(mk(0, 0, 0, 8'h00, 8'h10, 8'h10, HALT_WORD,     1, 1, 5));
        vecs.push_back(mk(0, 0, 0, 8'h00, 8'h10, 8'h10, NOP_WORD,      0, 1, 5));
        vecs.push_back(mk(0, 1, 0, 8'h00, 8'h10, 8'h10, NOP_WORD,      0, 1, 5));
        vecs.push_back(mk(0, 1, 1, 8'h04, 8'h04, 8'h10, NOP_WORD,      0, 0, 5));
        vecs.push_back(mk(0, 0, 0, 8'h00, 8'h08, 8'h04, 32'h0030_8113, 1, 0, 6));
        vecs.push_back(mk(0, 1, 1, 8'h23, 8'h20, 8'h04, NOP_WORD,      0, 0, 6));
        vecs.push_back(mk(0, 0, 0, 8'h00, 8'h24, 8'h20, 32'h1000_0008, 1, 0, 7));
        vecs.push_back(mk(0, 0, 1, 8'hF8, 8'hF8, 8'h20, NOP_WORD,      0, 0, 7));
        vecs.push_back(mk(0, 0, 0, 8'h00, 8'hFC, 8'hF8, 32'h1000_003E, 1, 0, 8));
        vecs.push_back(mk(0, 0, 0, 8'h00, 8'hFC, 8'hFC, 32'h1000_003F, 1, 1, 9));
        vecs.push_back(mk(0, 0, 0, 8'h00, 8'hFC, 8'hFC, NOP_WORD,      0, 1, 9));
        vecs.push_back(mk(0, 0, 1, 8'hFC, 8'hFC, 8'hFC, NOP_WORD,      0, 0, 9));
        vecs.push_back(mk(0, 0, 0, 8'h00, 8'hFC, 8'hFC, 32'h1000_003F, 1, 1, 10));
        vecs.push_back(mk(0, 0, 1, 8'h00, 8'h00, 8'hFC, NOP_WORD,      0, 0, 10));
        vecs.push_back(mk(0, 0, 0, 8'h00, 8'h04, 8'h00, 32'h0050_0093, 1, 0, 11));
        vecs.push_back(mk(1, 1, 1, 8'h40, 8'h00, 8'h00, NOP_WORD,      0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 8'h10, 8'h10, 8'h00, NOP_WORD,      0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 8'h09, 8'h08, 8'h00, NOP_WORD,      0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 8'h0C, 8'h08, 32'h1000_0002, 1, 0, 1));

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            drive_cycle(vecs[i].rst, vecs[i].stall, vecs[i].rv, vecs[i].rpc);
            check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_ifpc, vecs[i].e_instr,
                      vecs[i].e_valid, vecs[i].e_halt, vecs[i].e_cnt);
        end

        // Hand sequence: halt word reached after a stall inside the halt cycle.
        drive_cycle(0, 0, 1, 8'h0C);
        drive_cycle(0, 0, 0, 8'h00);
        drive_cycle(0, 1, 0, 8'h00);
        check_all("seq_stall_before_halt", 8'h10, 8'h0C, 32'h1000_0003, 1, 0, 2);
        drive_cycle(0, 0, 0, 8'h00);
        check_all("seq_halt_after_stall", 8'h10, 8'h10, HALT_WORD, 1, 1, 3);

        // ------------------------------------------------------------ random
        for (int i = 0; i < 64; i++) begin
            imem[i] = ($urandom_range(0, 9) == 0) ? HALT_WORD : $urandom;
        end
        drive_cycle(1, 0, 0, 8'h00);
        model_step(1, 0, 0, 8'h00);
        for (int c = 0; c < 3000; c++) begin
            logic r, s, rv;
            logic [7:0] rp;
            r  = ($urandom_range(0, 199) == 0);
            s  = ($urandom_range(0, 4) == 0);
            rv = ($urandom_range(0, 14) == 0);
            rp = 8'($urandom_range(0, 255));
            model_step(r, s, rv, rp);
            drive_cycle(r, s, rv, rp);
            check_all("rand", m_pc, m_ifpc, m_instr, m_valid, !m_running, 16'(m_cnt));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
